// File: rtl/memory_pkg.sv
// Shared memory-subsystem definitions.
// Provides the bus widths used by mem_read_write, the access-size encoding carried on
// N_BYTES and the number of byte lanes per memory word.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned MEM_WORD_WIDTH = 32;
  localparam int unsigned MEM_LANES      = MEM_WORD_WIDTH / 8;

  // Access size on N_BYTES.
  typedef enum logic [1:0] {
    NB_BYTE = 2'd0,
    NB_HALF = 2'd1,
    NB_WORD = 2'd2,
    NB_RSVD = 2'd3
  } nbytes_e;

endpackage

// File: rtl/mem_read_write.sv
// Load/store bus between the core and a data memory.
// core_side drives a request (REQ, WRITE_EN, L_UNSIGNED, N_BYTES, ADDR, W_DATA);
// mem_side answers one cycle later with R_DATA and ADDR_ERR.
interface mem_read_write;

  logic                                  REQ;
  logic                                  WRITE_EN;
  logic                                  L_UNSIGNED;
  logic [1:0]                            N_BYTES;
  logic [memory_pkg::MEM_ADDR_WIDTH-1:0] ADDR;
  logic [memory_pkg::MEM_WORD_WIDTH-1:0] W_DATA;
  logic                                  ADDR_ERR;
  logic [memory_pkg::MEM_WORD_WIDTH-1:0] R_DATA;

  modport mem_side (
    input  REQ, WRITE_EN, L_UNSIGNED, N_BYTES, ADDR, W_DATA,
    output ADDR_ERR, R_DATA
  );

  modport core_side (
    output REQ, WRITE_EN, L_UNSIGNED, N_BYTES, ADDR, W_DATA,
    input  ADDR_ERR, R_DATA
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory.
// Store side: from access size, byte lane and W_DATA produce per-lane write strobes and
//   write data replicated into the selected lanes.
// Load side: from the stored word, access size, lane and L_UNSIGNED produce the
//   right-justified, sign- or zero-extended load result.
// Ports:
//   n_bytes_i, lane_i        - access size and byte offset within the word
//   w_data_i / l_unsigned_i  - store data / load extension select
//   r_word_i                 - full word read from the array
//   wstrb_o, w_data_o        - lane write enables and lane-aligned store data
//   r_data_o                 - extended load result
module dmem_lane_align
  import memory_pkg::*;
(
  input  nbytes_e                   n_bytes_i,
  input  logic [1:0]                lane_i,
  input  logic [MEM_WORD_WIDTH-1:0] w_data_i,
  input  logic                      l_unsigned_i,
  input  logic [MEM_WORD_WIDTH-1:0] r_word_i,
  output logic [MEM_LANES-1:0]      wstrb_o,
  output logic [MEM_WORD_WIDTH-1:0] w_data_o,
  output logic [MEM_WORD_WIDTH-1:0] r_data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    wstrb_o  = '0;
    w_data_o = '0;
    case (n_bytes_i)
      NB_BYTE: begin
        wstrb_o  = 4'b0001 << lane_i;
        w_data_o = {4{w_data_i[7:0]}};
      end
      NB_HALF: begin
        wstrb_o  = lane_i[1] ? 4'b1100 : 4'b0011;
        w_data_o = {2{w_data_i[15:0]}};
      end
      NB_WORD: begin
        wstrb_o  = 4'b1111;
        w_data_o = w_data_i;
      end
      default: begin
        wstrb_o  = '0;
        w_data_o = '0;
      end
    endcase
  end

  always_comb begin
    sel_byte = r_word_i[{lane_i, 3'b000} +: 8];
    sel_half = lane_i[1] ? r_word_i[31:16] : r_word_i[15:0];
    r_data_o = '0;
    case (n_bytes_i)
      NB_BYTE: r_data_o = {{24{sel_byte[7] & ~l_unsigned_i}}, sel_byte};
      NB_HALF: r_data_o = {{16{sel_half[15] & ~l_unsigned_i}}, sel_half};
      NB_WORD: r_data_o = r_word_i;
      default: r_data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed, word-organised data RAM serving the mem_side of mem_read_write.
// Every request gets its response (R_DATA, ADDR_ERR) registered one cycle later.
// Misaligned, reserved-size and out-of-range requests raise a one-cycle ADDR_ERR pulse,
// return zero and never write the array.
// Ports:
//   clk    - clock, all state updates on its rising edge
//   rst_n  - synchronous active-low reset (clears outputs, blocks writes)
//   dmem   - mem_read_write.mem_side request/response bundle
module data_memory
  import memory_pkg::*;
#(
  parameter int unsigned               DEPTH_WORDS = 1024,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter string                     INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_read_write.mem_side  dmem
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One bit wider than the address so the capacity itself is representable.
  localparam logic [MEM_ADDR_WIDTH:0] CapBytes = {1'b0, MEM_ADDR_WIDTH'(DEPTH_WORDS)} << 2;

  logic [MEM_LANES-1:0][7:0] mem [DEPTH_WORDS];

  logic [MEM_ADDR_WIDTH-1:0] off;
  logic [IdxW-1:0]           idx;
  nbytes_e                   nb;
  logic                      err;
  logic                      req_err;
  logic                      do_store;
  logic                      do_load;
  logic [MEM_LANES-1:0]      wstrb;
  logic [MEM_WORD_WIDTH-1:0] w_lanes;
  logic [MEM_WORD_WIDTH-1:0] rd_word;
  logic [MEM_WORD_WIDTH-1:0] load_data;
  logic [MEM_WORD_WIDTH-1:0] r_data_q;
  logic                      addr_err_q;

  // Modulo subtraction: addresses below BASE_ADDR wrap high and fail the range check.
  assign off = dmem.ADDR - BASE_ADDR;
  assign idx = off[IdxW+1:2];
  assign nb  = nbytes_e'(dmem.N_BYTES);

  always_comb begin
    err = ({1'b0, off} >= CapBytes);
    case (nb)
      NB_HALF: if (off[0])            err = 1'b1;
      NB_WORD: if (off[1:0] != 2'b00) err = 1'b1;
      NB_RSVD:                        err = 1'b1;
      default: ;
    endcase
  end

  assign req_err  = dmem.REQ & err;
  assign do_store = dmem.REQ & dmem.WRITE_EN & ~err & rst_n;
  assign do_load  = dmem.REQ & ~dmem.WRITE_EN & ~err;
  assign rd_word  = mem[idx];

  dmem_lane_align u_align (
    .n_bytes_i    (nb),
    .lane_i       (off[1:0]),
    .w_data_i     (dmem.W_DATA),
    .l_unsigned_i (dmem.L_UNSIGNED),
    .r_word_i     (rd_word),
    .wstrb_o      (wstrb),
    .w_data_o     (w_lanes),
    .r_data_o     (load_data)
  );

  // Byte-write array; no reset so it maps onto block RAM with lane enables.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int l = 0; l < MEM_LANES; l++) begin
        if (wstrb[l]) mem[idx][l] <= w_lanes[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= req_err;
      if (req_err) begin
        r_data_q <= '0;
      end else if (do_load) begin
        r_data_q <= load_data;
      end
    end
  end

  assign dmem.R_DATA   = r_data_q;
  assign dmem.ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (default instance plus one with
// BASE_ADDR=0x2000).
module tb_data_memory;
  import memory_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mem_read_write bus_a ();
  mem_read_write bus_b ();

  data_memory u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dmem  (bus_a)
  );

  data_memory #(
    .BASE_ADDR (32'h0000_2000)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .dmem  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request on bus_a, let one edge pass, then drop REQ. Outputs are valid on
  // return; the caller has until the next edge to sample them or issue again.
  task automatic issue(input logic we, input logic uns, input logic [1:0] nb,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus_a.REQ        = 1'b1;
    bus_a.WRITE_EN   = we;
    bus_a.L_UNSIGNED = uns;
    bus_a.N_BYTES    = nb;
    bus_a.ADDR       = addr;
    bus_a.W_DATA     = wd;
    @(posedge clk);
    #1;
    bus_a.REQ = 1'b0;
  endtask

  task automatic issue_b(input logic we, input logic uns, input logic [1:0] nb,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus_b.REQ        = 1'b1;
    bus_b.WRITE_EN   = we;
    bus_b.L_UNSIGNED = uns;
    bus_b.N_BYTES    = nb;
    bus_b.ADDR       = addr;
    bus_b.W_DATA     = wd;
    @(posedge clk);
    #1;
    bus_b.REQ = 1'b0;
  endtask

  task automatic idle();
    bus_a.REQ = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Known content written before reset.
    issue(1'b1, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D);
    rst_n            = 1'b0;
    bus_a.REQ        = 1'b1;
    bus_a.WRITE_EN   = 1'b1;
    bus_a.L_UNSIGNED = 1'b0;
    bus_a.N_BYTES    = 2'd2;
    bus_a.ADDR       = 32'h0;
    bus_a.W_DATA     = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.R_DATA !== 32'h0)
        $display("FAIL reset_rdata cyc %0d: got %h want 00000000", i, bus_a.R_DATA);
      else n_pass++;
      n_total++;
      if (bus_a.ADDR_ERR !== 1'b0)
        $display("FAIL reset_err cyc %0d: got %b want 0", i, bus_a.ADDR_ERR);
      else n_pass++;
    end
    bus_a.REQ = 1'b0;
    rst_n     = 1'b1;
    idle();
    n_total++;
    if (bus_a.R_DATA !== 32'h0 || bus_a.ADDR_ERR !== 1'b0)
      $display("FAIL reset_dropped: got %h/%b want 00000000/0", bus_a.R_DATA, bus_a.ADDR_ERR);
    else n_pass++;
    issue(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'hCAFE_F00D)
      $display("FAIL reset_no_write: got %h want cafef00d", bus_a.R_DATA);
    else n_pass++;
  endtask

  task automatic test_store_sub();
    issue(1'b1, 1'b0, 2'd2, 32'h10, 32'h8899_AABB);
    n_total++;
    if (bus_a.R_DATA !== 32'hCAFE_F00D)
      $display("FAIL store_holds_rdata: got %h want cafef00d", bus_a.R_DATA);
    else n_pass++;
    // Upper bits of W_DATA must be ignored for a byte store.
    issue(1'b1, 1'b0, 2'd0, 32'h12, 32'hFFFF_FF11);
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h8811_AABB)
      $display("FAIL word_after_byte: got %h want 8811aabb", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b0, 2'd0, 32'h13, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'hFFFF_FF88)
      $display("FAIL lb_signed: got %h want ffffff88", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b1, 2'd1, 32'h12, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h0000_8811)
      $display("FAIL lhu: got %h want 00008811", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b0, 2'd1, 32'h12, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'hFFFF_8811)
      $display("FAIL lh_signed: got %h want ffff8811", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b1, 2'd0, 32'h11, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h0000_00AA)
      $display("FAIL lbu_lane1: got %h want 000000aa", bus_a.R_DATA);
    else n_pass++;
    // Half store into the upper half leaves the lower half alone.
    issue(1'b1, 1'b0, 2'd1, 32'h16, 32'h1234_BEEF);
    issue(1'b0, 1'b0, 2'd2, 32'h14, 32'h0);
    n_total++;
    if (bus_a.R_DATA[31:16] !== 16'hBEEF)
      $display("FAIL sh_upper: got %h want beef", bus_a.R_DATA[31:16]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 2'd2, 32'h20, 32'h1234_5678);
    issue(1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h1234_5678 || bus_a.ADDR_ERR !== 1'b0)
      $display("FAIL st_then_ld: got %h/%b want 12345678/0", bus_a.R_DATA, bus_a.ADDR_ERR);
    else n_pass++;
    issue(1'b0, 1'b1, 2'd0, 32'h21, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h0000_0056)
      $display("FAIL ld_ld_first: got %h want 00000056", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b1, 2'd1, 32'h22, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h0000_1234)
      $display("FAIL ld_ld_second: got %h want 00001234", bus_a.R_DATA);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic        we_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  nb_t [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad_t [4] = '{32'h21, 32'h22, 32'h0, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
      issue(we_t[i], 1'b0, nb_t[i], ad_t[i], 32'hAAAA_AAAA);
      n_total++;
      if (bus_a.ADDR_ERR !== 1'b1 || bus_a.R_DATA !== 32'h0)
        $display("FAIL err_case %0d: got %b/%h want 1/00000000", i, bus_a.ADDR_ERR,
                 bus_a.R_DATA);
      else n_pass++;
      idle();
      n_total++;
      if (bus_a.ADDR_ERR !== 1'b0)
        $display("FAIL err_pulse %0d: got %b want 0", i, bus_a.ADDR_ERR);
      else n_pass++;
    end
    issue(1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h1234_5678)
      $display("FAIL err_no_write_20: got %h want 12345678", bus_a.R_DATA);
    else n_pass++;
    issue(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'hCAFE_F00D)
      $display("FAIL err_no_write_0: got %h want cafef00d", bus_a.R_DATA);
    else n_pass++;
    // Last valid word is accepted.
    issue(1'b1, 1'b0, 2'd2, 32'hFFC, 32'h5A5A_0001);
    issue(1'b0, 1'b0, 2'd2, 32'hFFC, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h5A5A_0001 || bus_a.ADDR_ERR !== 1'b0)
      $display("FAIL last_word: got %h/%b want 5a5a0001/0", bus_a.R_DATA, bus_a.ADDR_ERR);
    else n_pass++;
  endtask

  task automatic test_base();
    issue_b(1'b1, 1'b0, 2'd2, 32'h2000, 32'h0BAD_F00D);
    issue_b(1'b0, 1'b0, 2'd2, 32'h2000, 32'h0);
    n_total++;
    if (bus_b.R_DATA !== 32'h0BAD_F00D || bus_b.ADDR_ERR !== 1'b0)
      $display("FAIL base_word0: got %h/%b want 0badf00d/0", bus_b.R_DATA, bus_b.ADDR_ERR);
    else n_pass++;
    issue_b(1'b0, 1'b0, 2'd2, 32'h1FFC, 32'h0);
    n_total++;
    if (bus_b.ADDR_ERR !== 1'b1 || bus_b.R_DATA !== 32'h0)
      $display("FAIL base_below: got %b/%h want 1/00000000", bus_b.ADDR_ERR, bus_b.R_DATA);
    else n_pass++;
    issue_b(1'b0, 1'b0, 2'd2, 32'h3000, 32'h0);
    n_total++;
    if (bus_b.ADDR_ERR !== 1'b1)
      $display("FAIL base_above: got %b want 1", bus_b.ADDR_ERR);
    else n_pass++;
  endtask

  task automatic test_hold();
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      n_total++;
      if (bus_a.R_DATA !== 32'h8811_AABB || bus_a.ADDR_ERR !== 1'b0)
        $display("FAIL hold_idle %0d: got %h/%b want 8811aabb/0", i, bus_a.R_DATA,
                 bus_a.ADDR_ERR);
      else n_pass++;
    end
    issue(1'b1, 1'b0, 2'd2, 32'h40, 32'h7777_7777);
    n_total++;
    if (bus_a.R_DATA !== 32'h8811_AABB)
      $display("FAIL hold_store: got %h want 8811aabb", bus_a.R_DATA);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    n_total++;
    if (bus_a.R_DATA !== 32'h0)
      $display("FAIL mid_reset: got %h want 00000000", bus_a.R_DATA);
    else n_pass++;
    rst_n = 1'b1;
    idle();
    n_total++;
    if (bus_a.R_DATA !== 32'h0 || bus_a.ADDR_ERR !== 1'b0)
      $display("FAIL mid_reset_stale: got %h/%b want 00000000/0", bus_a.R_DATA,
               bus_a.ADDR_ERR);
    else n_pass++;
  endtask

  initial begin
    n_pass           = 0;
    n_total          = 0;
    rst_n            = 1'b1;
    bus_a.REQ        = 1'b0;
    bus_a.WRITE_EN   = 1'b0;
    bus_a.L_UNSIGNED = 1'b0;
    bus_a.N_BYTES    = 2'd0;
    bus_a.ADDR       = '0;
    bus_a.W_DATA     = '0;
    bus_b.REQ        = 1'b0;
    bus_b.WRITE_EN   = 1'b0;
    bus_b.L_UNSIGNED = 1'b0;
    bus_b.N_BYTES    = 2'd0;
    bus_b.ADDR       = '0;
    bus_b.W_DATA     = '0;
    test_reset();
    test_store_sub();
    test_back_to_back();
    test_errors();
    test_base();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
